// File: rtl/md_ctrl_if.sv
// Request-side MD busy/start bundle between md_ctrl and the E-stage MD datapath.
interface md_ctrl_if;
   logic       ostart;
   logic [2:0] oop;
   logic       obusy;
   logic       ooccupy;
   logic       ocommit;
   logic       ohi_we;
   logic       olo_we;

   modport master (
      output ostart, oop, obusy, ooccupy, ocommit, ohi_we, olo_we
   );

   modport slave (
      input ostart, oop, obusy, ooccupy, ocommit, ohi_we, olo_we
   );
endinterface

// File: rtl/md_ctrl.sv
// MD issue/sequencing controller: launches MULT/DIV ops, tracks latency, stalls D-stage MD
// instructions while the unit is occupied and counts stalled cycles.
module md_ctrl #(
   parameter int unsigned MUL_LAT = 5,
   parameter int unsigned DIV_LAT = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] iinstr_d,
   input  logic [31:0] iinstr_e,
   input  logic        iflush,
   md_ctrl_if.master   md,
   output logic        ostall,
   output logic [15:0] ostall_cnt
);

   localparam logic [3:0] MulLat = 4'(MUL_LAT);
   localparam logic [3:0] DivLat = 4'(DIV_LAT);

   typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

   state_e      state_q;
   logic [3:0]  count_q;
   logic [2:0]  op_q;
   logic        busy_q;
   logic [15:0] stall_cnt_q;

   logic [2:0]  e_op;
   logic        e_mthi, e_mtlo, d_md;
   logic [3:0]  lat;
   logic        start, commit;

   // Only opcode and funct take part in decode.
   logic unused_instr_bits;
   assign unused_instr_bits = ^{iinstr_d[25:6], iinstr_e[25:6]};

   always_comb begin
      e_op   = 3'd0;
      e_mthi = 1'b0;
      e_mtlo = 1'b0;
      d_md   = 1'b0;
      if (iinstr_e[31:26] == 6'd0) begin
         case (iinstr_e[5:0])
            6'h18:   e_op = 3'd1;
            6'h19:   e_op = 3'd2;
            6'h1a:   e_op = 3'd3;
            6'h1b:   e_op = 3'd4;
            6'h11:   e_mthi = 1'b1;
            6'h13:   e_mtlo = 1'b1;
            default: ;
         endcase
      end
      if (iinstr_d[31:26] == 6'd0) begin
         d_md = iinstr_d[5:0] inside {6'h10, 6'h11, 6'h12, 6'h13,
                                      6'h18, 6'h19, 6'h1a, 6'h1b};
      end
   end

   always_comb begin
      lat    = (op_q >= 3'd3) ? DivLat : MulLat;
      start  = (state_q == StIdle) && (e_op != 3'd0);
      commit = (state_q != StIdle) && (count_q == lat);
   end

   assign md.ostart  = start;
   assign md.oop     = start ? e_op : 3'd0;
   assign md.obusy   = busy_q;
   assign md.ooccupy = start | busy_q;
   assign md.ocommit = commit;
   assign md.ohi_we  = e_mthi & ~iflush;
   assign md.olo_we  = e_mtlo & ~iflush;
   assign ostall     = d_md & (start | busy_q);
   assign ostall_cnt = stall_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         count_q     <= 4'd0;
         op_q        <= 3'd0;
         busy_q      <= 1'b0;
         stall_cnt_q <= 16'd0;
      end else begin
         if (ostall && (stall_cnt_q != 16'hffff)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
         unique case (state_q)
            StIdle: begin
               // A flush in the issue cycle lets the pulse out but never occupies the unit.
               if (start && !iflush) begin
                  state_q <= (e_op <= 3'd2) ? StMul : StDiv;
                  count_q <= 4'd1;
                  op_q    <= e_op;
                  busy_q  <= 1'b1;
               end
            end
            StMul, StDiv: begin
               if ((iflush && (count_q == 4'd1)) || commit) begin
                  state_q <= StIdle;
                  count_q <= 4'd0;
                  op_q    <= 3'd0;
                  busy_q  <= 1'b0;
               end else begin
                  count_q <= count_q + 4'd1;
               end
            end
            default: begin
               state_q <= StIdle;
               count_q <= 4'd0;
               op_q    <= 3'd0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl with MUL_LAT=5, DIV_LAT=10.
module tb_md_ctrl;

   localparam logic [31:0] NOP   = 32'h0000_0000;
   localparam logic [31:0] MULT  = 32'h0000_0018;
   localparam logic [31:0] MULTU = 32'h0000_0019;
   localparam logic [31:0] DIV   = 32'h0000_001a;
   localparam logic [31:0] DIVU  = 32'h0000_001b;
   localparam logic [31:0] MFHI  = 32'h0000_0010;
   localparam logic [31:0] MTHI  = 32'h0000_0011;
   localparam logic [31:0] MFLO  = 32'h0000_0012;
   localparam logic [31:0] MTLO  = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] iinstr_d, iinstr_e;
   logic        iflush;
   logic        ostall;
   logic [15:0] ostall_cnt;
   int          checks = 0;
   int          errors = 0;

   md_ctrl_if mdi ();

   md_ctrl #(
      .MUL_LAT(5),
      .DIV_LAT(10)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .iinstr_d  (iinstr_d),
      .iinstr_e  (iinstr_e),
      .iflush    (iflush),
      .md        (mdi),
      .ostall    (ostall),
      .ostall_cnt(ostall_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] d, input logic [31:0] e, input logic f);
      iinstr_d = d;
      iinstr_e = e;
      iflush   = f;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(NOP, NOP, 1'b0);
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      drive(NOP, NOP, 1'b0);
      checks++;
      if ({mdi.ostart, mdi.oop, mdi.obusy, mdi.ooccupy, mdi.ocommit, ostall} !== 8'd0) begin
         errors++;
         $display("FAIL reset_outputs got %b want 0", {mdi.ostart, mdi.oop, mdi.obusy,
                  mdi.ooccupy, mdi.ocommit, ostall});
      end
      checks++;
      if (ostall_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_stall_cnt got %0d want 0", ostall_cnt);
      end
   endtask

   task automatic test_mult();
      do_reset();
      drive(NOP, MULT, 1'b0);
      checks++;
      if ({mdi.ostart, mdi.oop, mdi.obusy, mdi.ooccupy} !== {1'b1, 3'd1, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL mult_issue got start=%b op=%0d busy=%b occ=%b want 1 1 0 1",
                  mdi.ostart, mdi.oop, mdi.obusy, mdi.ooccupy);
      end
      for (int c = 1; c <= 6; c++) begin
         tick();
         drive(NOP, NOP, 1'b0);
         checks++;
         if ({mdi.obusy, mdi.ocommit} !== {(c <= 5), (c == 5)}) begin
            errors++;
            $display("FAIL mult_cycle%0d got busy=%b commit=%b want %b %b", c, mdi.obusy,
                     mdi.ocommit, (c <= 5), (c == 5));
         end
      end
   endtask

   task automatic test_divu_stall();
      do_reset();
      drive(NOP, DIVU, 1'b0);
      checks++;
      if (mdi.oop !== 3'd4) begin
         errors++;
         $display("FAIL divu_op got %0d want 4", mdi.oop);
      end
      for (int c = 1; c <= 11; c++) begin
         tick();
         drive(MFLO, NOP, 1'b0);
         checks++;
         if ({ostall, mdi.ocommit} !== {(c <= 10), (c == 10)}) begin
            errors++;
            $display("FAIL divu_cycle%0d got stall=%b commit=%b want %b %b", c, ostall,
                     mdi.ocommit, (c <= 10), (c == 10));
         end
      end
      checks++;
      if (ostall_cnt !== 16'd10) begin
         errors++;
         $display("FAIL divu_stall_cnt got %0d want 10", ostall_cnt);
      end
   endtask

   // Flush at count 1 aborts; flush at count 2 is ignored.
   task automatic test_abort();
      logic seen;
      do_reset();
      drive(NOP, DIV, 1'b0);
      seen = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         tick();
         drive(NOP, NOP, c == 1);
         seen = seen | mdi.ocommit;
         if (c == 2) begin
            checks++;
            if (mdi.obusy !== 1'b0) begin
               errors++;
               $display("FAIL abort1_busy got %b want 0", mdi.obusy);
            end
         end
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL abort1_commit got %b want 0", seen);
      end

      do_reset();
      drive(NOP, DIV, 1'b0);
      for (int c = 1; c <= 11; c++) begin
         tick();
         drive(NOP, NOP, c == 2);
         checks++;
         if ({mdi.obusy, mdi.ocommit} !== {(c <= 10), (c == 10)}) begin
            errors++;
            $display("FAIL flush2_cycle%0d got busy=%b commit=%b want %b %b", c, mdi.obusy,
                     mdi.ocommit, (c <= 10), (c == 10));
         end
      end

      do_reset();
      drive(NOP, MULT, 1'b1);
      checks++;
      if ({mdi.ostart, mdi.oop} !== {1'b1, 3'd1}) begin
         errors++;
         $display("FAIL flush0_start got %b %0d want 1 1", mdi.ostart, mdi.oop);
      end
      seen = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         tick();
         drive(NOP, NOP, 1'b0);
         seen = seen | mdi.obusy | mdi.ocommit;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL flush0_busy_or_commit got %b want 0", seen);
      end
   endtask

   task automatic test_flush_at_commit();
      do_reset();
      drive(NOP, DIV, 1'b0);
      for (int c = 1; c <= 10; c++) begin
         tick();
         drive(NOP, NOP, c == 10);
      end
      checks++;
      if (mdi.ocommit !== 1'b1) begin
         errors++;
         $display("FAIL flush_at_commit got %b want 1", mdi.ocommit);
      end
      tick();
      drive(NOP, NOP, 1'b0);
      checks++;
      if (mdi.obusy !== 1'b0) begin
         errors++;
         $display("FAIL flush_at_commit_idle got busy=%b want 0", mdi.obusy);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive(NOP, MULT, 1'b0);
      for (int c = 1; c <= 4; c++) begin
         tick();
         drive(NOP, NOP, 1'b0);
      end
      tick();
      drive(NOP, MULTU, 1'b0);
      checks++;
      if ({mdi.ostart, mdi.oop, mdi.ocommit} !== {1'b0, 3'd0, 1'b1}) begin
         errors++;
         $display("FAIL b2b_at_lat got start=%b op=%0d commit=%b want 0 0 1", mdi.ostart,
                  mdi.oop, mdi.ocommit);
      end
      tick();
      drive(NOP, MULTU, 1'b0);
      checks++;
      if ({mdi.ostart, mdi.oop, mdi.obusy} !== {1'b1, 3'd2, 1'b0}) begin
         errors++;
         $display("FAIL b2b_launch got start=%b op=%0d busy=%b want 1 2 0", mdi.ostart,
                  mdi.oop, mdi.obusy);
      end
      tick();
      drive(NOP, DIV, 1'b0);
      checks++;
      if ({mdi.obusy, mdi.ostart, mdi.oop} !== {1'b1, 1'b0, 3'd0}) begin
         errors++;
         $display("FAIL busy_no_launch got busy=%b start=%b op=%0d want 1 0 0", mdi.obusy,
                  mdi.ostart, mdi.oop);
      end
      // Second op is MULTU, so commit must arrive on its MUL latency despite DIV in E.
      for (int c = 2; c <= 5; c++) begin
         tick();
         drive(NOP, NOP, 1'b0);
      end
      checks++;
      if (mdi.ocommit !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second_commit got %b want 1", mdi.ocommit);
      end
   endtask

   task automatic test_reset_mid();
      logic seen;
      do_reset();
      drive(NOP, DIV, 1'b0);
      for (int c = 1; c <= 3; c++) begin
         tick();
         drive(MFHI, NOP, 1'b0);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive(NOP, NOP, 1'b0);
      checks++;
      if ({mdi.obusy, mdi.ocommit, mdi.ooccupy, ostall_cnt} !== 19'd0) begin
         errors++;
         $display("FAIL reset_mid got busy=%b commit=%b occ=%b cnt=%0d want 0 0 0 0",
                  mdi.obusy, mdi.ocommit, mdi.ooccupy, ostall_cnt);
      end
      seen = 1'b0;
      for (int c = 5; c <= 12; c++) begin
         tick();
         drive(NOP, NOP, 1'b0);
         seen = seen | mdi.ocommit;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_commit got %b want 0", seen);
      end
   endtask

   task automatic test_mthi_mtlo();
      do_reset();
      drive(NOP, MTHI, 1'b0);
      checks++;
      if ({mdi.ohi_we, mdi.olo_we} !== 2'b10) begin
         errors++;
         $display("FAIL mthi got %b want 10", {mdi.ohi_we, mdi.olo_we});
      end
      drive(NOP, MTHI, 1'b1);
      checks++;
      if ({mdi.ohi_we, mdi.olo_we} !== 2'b00) begin
         errors++;
         $display("FAIL mthi_flush got %b want 00", {mdi.ohi_we, mdi.olo_we});
      end
      drive(NOP, MTLO, 1'b0);
      checks++;
      if ({mdi.ohi_we, mdi.olo_we} !== 2'b01) begin
         errors++;
         $display("FAIL mtlo got %b want 01", {mdi.ohi_we, mdi.olo_we});
      end
   endtask

   task automatic test_saturate();
      do_reset();
      drive(MFHI, MULT, 1'b0);
      for (int c = 0; c < 65534; c++) begin
         @(posedge clk);
      end
      #1;
      checks++;
      if (ostall_cnt !== 16'hfffe) begin
         errors++;
         $display("FAIL sat_pre got %h want fffe", ostall_cnt);
      end
      for (int c = 0; c < 1000; c++) begin
         @(posedge clk);
      end
      #1;
      checks++;
      if ({ostall, ostall_cnt} !== {1'b1, 16'hffff}) begin
         errors++;
         $display("FAIL sat_hold got stall=%b cnt=%h want 1 ffff", ostall, ostall_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_divu_stall();
      test_abort();
      test_flush_at_commit();
      test_back_to_back();
      test_reset_mid();
      test_mthi_mtlo();
      test_saturate();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/md_ctrl.md
# md_ctrl

Issue and sequencing controller for the multiply/divide unit: the requesting side of the MD busy/start protocol. It watches the D- and E-stage instructions, launches MULT/MULTU/DIV/DIVU operations into the MD datapath, and tracks each operation's latency with its own FSM. It raises the D-stage stall for MD-class instructions while the unit is occupied, cancels early operations on exception flush, and signals HI/LO commit. It sits beside the E-stage MD datapath and feeds the hazard unit.

## Interface
- MUL_LAT, 5, cycles from issue edge to HI/LO commit edge for MULT/MULTU (2..15)
- DIV_LAT, 10, same for DIV/DIVU (2..15)
- clk  in  1  clock; all state changes on posedge
- reset  in  1  synchronous, active-high; one clock, single reset domain
- iinstr_d  in  32  instruction in D stage
- iinstr_e  in  32  instruction in E stage
- iflush  in  1  exception/interrupt cancel (disab)
- ostart  out  1  combinational; launch pulse to MD datapath this cycle
- oop  out  3  combinational with ostart: 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 0 none
- obusy  out  1  registered; operation in flight
- ooccupy  out  1  ostart | obusy
- ostall  out  1  D-stage stall request
- ocommit  out  1  high in the cycle whose closing edge writes HI/LO
- ohi_we, olo_we  out  1 each  MTHI/MTLO write enables for E stage
- ostall_cnt  out  16  saturating count of stalled cycles

## Operation
- Decode (opcode 0): MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MFHI 0x10, MTHI 0x11, MFLO 0x12, MTLO 0x13. MD-class = any of the eight.
- FSM states: IDLE, MUL, DIV. Internal 4-bit count, 0 in IDLE.
- ostart = E-instr is MULT/MULTU/DIV/DIVU and state==IDLE. oop = matching code when ostart, else 0.
- IDLE -> MUL (MULT/MULTU) or DIV (DIV/DIVU) on edge with ostart and no abort; count <= 1, latched op held.
- MUL/DIV: count increments each cycle; at count==LAT, ocommit=1 and next edge returns to IDLE, count 0, op 0.
- ostall = D-instr MD-class and ooccupy. Computed independent of iflush.
- ohi_we = E-instr MTHI and not iflush; olo_we likewise. MTHI/MTLO never coexists with busy in E (stalled in D); if it does, write enables still follow the rule.
- Abort: iflush with count in {0,1}. At count 0: ostart still asserted combinationally but no state change (datapath also discards). At count 1: return to IDLE, count 0, no ocommit ever. iflush at count >= 2 ignored; operation completes and commits.
- E-stage MD op while busy: no launch, state unchanged.
- ostall_cnt += 1 each edge with ostall=1, saturates at 0xFFFF.

## Timing
- Reset values: state IDLE, count 0, obusy 0, ocommit 0, ostart/oop 0 given no MD instr, ostall_cnt 0.
- Issue cycle T: ostart=1, ooccupy=1, obusy=0. T+1..T+LAT: obusy=1. ocommit in T+LAT; HI/LO valid from T+LAT+1, obusy=0 there.
- Back-to-back: next op in E may launch at T+LAT+1 (IDLE), not at T+LAT.
- Reset mid-operation wins over everything: IDLE next cycle, no ocommit.
- Simultaneous iflush and count==LAT (LAT>=2): commit proceeds.

## Test plan
- MULT in E at cycle 0 -> ostart=1, oop=1 at 0; obusy 1..5; ocommit at 5 only; obusy=0 at 6.
- DIVU in E at 0, MFLO in D at 1..10 -> ostall=1 cycles 1..10, ocommit at 10, ostall=0 at 11, ostall_cnt=10.
- DIV issued at 0, iflush at 1 (count 1) -> IDLE at 2, no ocommit; iflush at 2 instead -> ocommit at 10.
- MULT with iflush in issue cycle -> ostart=1 but obusy stays 0, no ocommit.
- reset asserted at count 3 of DIV -> all outputs reset values next cycle, no ocommit; MTHI in E without flush -> ohi_we=1, with iflush -> 0.
- Hold MFHI in D with continuous MULT stream for 70000 cycles -> ostall_cnt saturates at 0xFFFF.
